// File: rtl/icache_refill_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_pkg
// Shared definitions for the instruction-cache refill engine:
//   - refill FSM state encoding (IDLE/ARB/READ/WRITE, 2 bits)
//   - REFILL_BYTES : number of bytes fetched per miss
//   - OPC_MASK     : low opcode bits that mark a full-width (non-compressed) inst
//   - is_compressed(): RISC-V compressed-instruction detect
//   - byte_off()   : read counter -> byte offset, saturating at the last byte
// -----------------------------------------------------------------------------
package icache_refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int         REFILL_BYTES = 4;
    localparam logic [1:0] OPC_MASK     = 2'b11;

    function automatic logic is_compressed(input logic [31:0] inst);
        return (inst[1:0] & OPC_MASK) != OPC_MASK;
    endfunction

    // Past the last byte the address is a don't-care; hold it on the last byte.
    function automatic logic [1:0] byte_off(input logic [2:0] cnt);
        return (cnt > 3'd3) ? 2'd3 : cnt[1:0];
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// -----------------------------------------------------------------------------
// icache_refill_if
// Bundles the fetch request, RAM arbiter/bus and ICache/fetch result signals.
//   slave  : the refill engine (accepts fetch misses, masters the RAM port)
//   master : the surrounding system (fetch, arbiter, RAM, ICache)
// Fetch : req_valid, req_addr -> ; <- req_ready
// RAM   : <- mem_req, mem_a, mem_wr ; mem_gnt, mem_din ->
// Cache : <- cache_wr, cache_addr, cache_inst
// Fetch : <- done_valid, done_inst, done_is_c
// -----------------------------------------------------------------------------
interface icache_refill_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;

    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic [7:0]        mem_din;

    logic              cache_wr;
    logic [ADDR_W-1:0] cache_addr;
    logic [31:0]       cache_inst;

    logic              done_valid;
    logic [31:0]       done_inst;
    logic              done_is_c;

    modport slave (
        input  req_valid, req_addr, mem_gnt, mem_din,
        output req_ready, mem_req, mem_a, mem_wr,
               cache_wr, cache_addr, cache_inst,
               done_valid, done_inst, done_is_c
    );

    modport master (
        output req_valid, req_addr, mem_gnt, mem_din,
        input  req_ready, mem_req, mem_a, mem_wr,
               cache_wr, cache_addr, cache_inst,
               done_valid, done_inst, done_is_c
    );
endinterface

// File: rtl/icache_refill_byte_asm.sv
// -----------------------------------------------------------------------------
// icache_refill_byte_asm
// Lane register that assembles REFILL_BYTES bytes into a little-endian word.
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous reset, active low
//   clr     : clear all lanes (already qualified by the global ready)
//   cap     : write din into lane 'lane' (already qualified by the global ready)
//   lane    : target byte lane, 0 = least significant
//   din     : incoming RAM byte
//   word    : assembled word {lane3, lane2, lane1, lane0}
// -----------------------------------------------------------------------------
module icache_refill_byte_asm
    import icache_refill_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clr,
    input  logic        cap,
    input  logic [1:0]  lane,
    input  logic [7:0]  din,
    output logic [31:0] word
);

    genvar gi;
    generate
        for (gi = 0; gi < REFILL_BYTES; gi++) begin : g_lane
            logic [7:0] byte_reg;

            always_ff @(posedge clk_in) begin
                if (!rst_in || clr) begin
                    byte_reg <= 8'h00;
                end else if (cap && (lane == 2'(gi))) begin
                    byte_reg <= din;
                end
            end

            assign word[gi*8 +: 8] = byte_reg;
        end
    endgenerate

endmodule

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
// ICache miss-refill engine. On an accepted fetch miss it requests the
// byte-wide RAM port, reads 4 consecutive bytes (address wraps mod 2^ADDR_W),
// assembles them little-endian, then issues one ICache write strobe together
// with a one-cycle result pulse to fetch. rob_clear_up aborts any refill.
// Ports:
//   clk_in       : clock
//   rst_in       : synchronous reset, active low; overrides rdy_in and flush
//   rdy_in       : global ready; low freezes every register
//   rob_clear_up : pipeline flush
//   bus          : icache_refill_if.slave (fetch, RAM, ICache, result)
//   stat_miss    : completed refills      (only with ICACHE_REFILL_STATS_EN)
//   stat_abort   : flush-aborted refills  (only with ICACHE_REFILL_STATS_EN)
// Parameters:
//   ADDR_W  : address width, must match the interface instance
//   MEM_LAT : RAM read latency in cycles (1 is the supported value)
// Optional build macro: ICACHE_REFILL_STATS_EN adds the two statistic counters.
// -----------------------------------------------------------------------------
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
`ifdef ICACHE_REFILL_STATS_EN
    output logic [31:0] stat_miss,
    output logic [31:0] stat_abort,
`endif
    icache_refill_if.slave bus
);

    localparam logic [2:0] LAT      = 3'(MEM_LAT);
    // The read counter keeps running MEM_LAT cycles past the last address so
    // the final byte can arrive.
    localparam logic [2:0] CNT_LAST = 3'(REFILL_BYTES + MEM_LAT - 1);

    state_t            state_reg;
    logic [2:0]        cnt_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] mem_a_reg;
    logic              req_ready_reg;
    logic              mem_req_reg;
    logic              write_reg;

    logic              busy;
    logic              flush_go;
    logic              accept;
    logic              strobe;
    logic              asm_clr;
    logic              asm_cap;
    logic [1:0]        asm_lane;
    logic [31:0]       word;

    assign busy     = (state_reg != ST_IDLE);
    assign flush_go = rdy_in && rob_clear_up && busy;
    // A miss arriving together with a flush is refused; fetch re-presents it.
    assign accept   = rdy_in && !busy && bus.req_valid && !rob_clear_up;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 3'd0;
            base_reg      <= '0;
            mem_a_reg     <= '0;
            req_ready_reg <= 1'b1;
            mem_req_reg   <= 1'b0;
            write_reg     <= 1'b0;
        end else if (rdy_in) begin
            if (flush_go) begin
                state_reg     <= ST_IDLE;
                cnt_reg       <= 3'd0;
                mem_a_reg     <= '0;
                req_ready_reg <= 1'b1;
                mem_req_reg   <= 1'b0;
                write_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (accept) begin
                            base_reg      <= bus.req_addr;
                            state_reg     <= ST_ARB;
                            req_ready_reg <= 1'b0;
                            mem_req_reg   <= 1'b1;
                        end
                    end
                    ST_ARB: begin
                        if (bus.mem_gnt) begin
                            state_reg <= ST_READ;
                            cnt_reg   <= 3'd0;
                            mem_a_reg <= base_reg;
                        end
                    end
                    ST_READ: begin
                        // Grant is assumed held once given; it is not re-checked here.
                        if (cnt_reg == CNT_LAST) begin
                            state_reg   <= ST_WRITE;
                            mem_req_reg <= 1'b0;
                            write_reg   <= 1'b1;
                            mem_a_reg   <= '0;
                        end else begin
                            cnt_reg   <= cnt_reg + 3'd1;
                            mem_a_reg <= base_reg + ADDR_W'(byte_off(cnt_reg + 3'd1));
                        end
                    end
                    ST_WRITE: begin
                        state_reg     <= ST_IDLE;
                        cnt_reg       <= 3'd0;
                        write_reg     <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Byte for counter value c arrives MEM_LAT cycles later, i.e. lane c-MEM_LAT.
    assign asm_cap  = rdy_in && !rob_clear_up && (state_reg == ST_READ) && (cnt_reg >= LAT);
    assign asm_lane = 2'(cnt_reg - LAT);
    assign asm_clr  = accept || flush_go;

    icache_refill_byte_asm u_asm (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (asm_clr),
        .cap    (asm_cap),
        .lane   (asm_lane),
        .din    (bus.mem_din),
        .word   (word)
    );

    // A flush landing on the WRITE cycle kills the strobe in that same cycle.
    // During a stall the flush is not acted on, so the pulse is kept.
    assign strobe = write_reg && !(rdy_in && rob_clear_up);

    assign bus.req_ready  = req_ready_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_a      = mem_a_reg;
    assign bus.mem_wr     = 1'b0;
    assign bus.cache_wr   = strobe;
    assign bus.cache_addr = write_reg ? base_reg : '0;
    assign bus.cache_inst = word;
    assign bus.done_valid = strobe;
    assign bus.done_inst  = word;
    assign bus.done_is_c  = write_reg && is_compressed(word);

`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0] stat_miss_reg;
    logic [31:0] stat_abort_reg;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            stat_miss_reg  <= 32'd0;
            stat_abort_reg <= 32'd0;
        end else if (rdy_in) begin
            if (write_reg && !rob_clear_up) begin
                stat_miss_reg <= stat_miss_reg + 32'd1;
            end
            if (flush_go) begin
                stat_abort_reg <= stat_abort_reg + 32'd1;
            end
        end
    end

    assign stat_miss  = stat_miss_reg;
    assign stat_abort = stat_abort_reg;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// -----------------------------------------------------------------------------
// tb_icache_refill
// Directed bench for icache_refill. A byte RAM model answers mem_a one cycle
// later; expected refill results are queued when a miss is issued and are
// popped and compared whenever the DUT raises its cache write strobe.
// Build with ICACHE_REFILL_STATS_EN defined to also exercise the counters.
// -----------------------------------------------------------------------------
module tb_icache_refill;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic rob_clear_up;

    always #5 clk_in = ~clk_in;

    icache_refill_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0] stat_miss;
    logic [31:0] stat_abort;
`endif

    icache_refill #(.ADDR_W(32), .MEM_LAT(1)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_clear_up (rob_clear_up),
`ifdef ICACHE_REFILL_STATS_EN
        .stat_miss    (stat_miss),
        .stat_abort   (stat_abort),
`endif
        .bus          (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        is_c;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ram [logic [31:0]];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         strobes  = 0;
    int         pushes   = 0;

    // RAM model: one cycle read latency, frozen with the rest of the system.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            ram[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    task automatic expect_word(input logic [31:0] a, input logic [31:0] w);
        exp_t e;
        e.addr = a;
        e.inst = w;
        e.is_c = (w[1:0] != 2'b11);
        sb.push_back(e);
        pushes++;
    endtask

    // Scoreboard consumer: one comparison set per write strobe.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in && rdy_in && bus.cache_wr) begin
            strobes++;
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed strobe addr 0x%08h expected no strobe", bus.cache_addr);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cache_addr", bus.cache_addr, e.addr);
                chk("cache_inst", bus.cache_inst, e.inst);
                chk("done_inst",  bus.done_inst,  e.inst);
                chk("done_valid", 32'(bus.done_valid), 32'd1);
                chk("done_is_c",  32'(bus.done_is_c),  32'(e.is_c));
                $display("txn addr=0x%08h inst=0x%08h is_c=%0b", bus.cache_addr, bus.cache_inst, bus.done_is_c);
            end
        end
    end

    // Full miss with grant already high; checks the documented cycle timing.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] w, input string tag);
        load_word(a, w);
        expect_word(a, w);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        tick(1);                                   // T+1: ARB
        bus.req_valid = 1'b0;
        chk({tag, "_arb_mem_req"}, 32'(bus.mem_req), 32'd1);
        tick(1);                                   // T+2: READ cnt 0
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_mem_a"}, bus.mem_a, a + 32'(i));
            chk({tag, "_read_mem_req"}, 32'(bus.mem_req), 32'd1);
            tick(1);
        end
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        chk({tag, "_cnt4_no_wr"}, 32'(bus.cache_wr), 32'd0);
        tick(1);                                   // T+7: WRITE
        chk({tag, "_cache_wr"}, 32'(bus.cache_wr), 32'd1);
        chk({tag, "_write_mem_req"}, 32'(bus.mem_req), 32'd0);
        tick(1);                                   // T+8: back in IDLE
        chk({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_idle_no_wr"}, 32'(bus.cache_wr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;

        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        rob_clear_up  = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.mem_gnt   = 1'b0;
        tick(2);

        // Reset state
        chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_mem_req",    32'(bus.mem_req),    32'd0);
        chk("rst_mem_a",      bus.mem_a,           32'd0);
        chk("rst_mem_wr",     32'(bus.mem_wr),     32'd0);
        chk("rst_cache_wr",   32'(bus.cache_wr),   32'd0);
        chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst_done_is_c",  32'(bus.done_is_c),  32'd0);
        chk("rst_cache_inst", bus.cache_inst,      32'd0);
        rst_in = 1'b1;
        tick(1);

        // Flush together with req_valid in IDLE: not accepted
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_9000;
        rob_clear_up  = 1'b1;
        tick(1);
        bus.req_valid = 1'b0;
        rob_clear_up  = 1'b0;
        chk("flushreq_ready",   32'(bus.req_ready), 32'd1);
        chk("flushreq_mem_req", 32'(bus.mem_req),   32'd0);

        // Basic miss and compressed/wrap miss with immediate grant
        bus.mem_gnt = 1'b1;
        do_miss(32'h0000_1000, 32'h0010_0513, "basic");
        do_miss(32'hFFFF_FFFE, 32'h8082_4501, "wrap");

        // Grant delayed three cycles plus a two-cycle stall mid-READ
        bus.mem_gnt = 1'b0;
        load_word(32'h0000_3000, 32'h0000_0197);
        expect_word(32'h0000_3000, 32'h0000_0197);
        s0 = strobes;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_3000;
        tick(1);                                   // T+1
        bus.req_valid = 1'b0;
        tick(2);                                   // T+3
        chk("gdly_arb_wait", 32'(bus.mem_req), 32'd1);
        tick(1);                                   // T+4
        bus.mem_gnt = 1'b1;
        tick(1);                                   // T+5 READ cnt 0
        chk("gdly_mem_a0", bus.mem_a, 32'h0000_3000);
        tick(2);                                   // T+7 READ cnt 2
        chk("gdly_mem_a2", bus.mem_a, 32'h0000_3002);
        rdy_in = 1'b0;
        tick(1);
        chk("stall_mem_a_1", bus.mem_a, 32'h0000_3002);
        tick(1);
        chk("stall_mem_a_2", bus.mem_a, 32'h0000_3002);
        rdy_in = 1'b1;
        tick(1);                                   // T+10
        chk("stall_mem_a3", bus.mem_a, 32'h0000_3003);
        tick(1);                                   // T+11
        chk("stall_no_wr_early", 32'(bus.cache_wr), 32'd0);
        tick(1);                                   // T+12
        chk("stall_cache_wr", 32'(bus.cache_wr), 32'd1);
        tick(1);
        chk("stall_ready", 32'(bus.req_ready), 32'd1);
        chk("stall_one_done", 32'(strobes - s0), 32'd1);

        // Flush at READ cnt 2
        load_word(32'h0000_4000, 32'hDEAD_BEEF);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_4000;
        tick(1);
        bus.req_valid = 1'b0;
        tick(3);                                   // T+4 READ cnt 2
        chk("flush_mem_a2", bus.mem_a, 32'h0000_4002);
        rob_clear_up = 1'b1;
        tick(1);
        rob_clear_up = 1'b0;
        chk("flush_mem_req", 32'(bus.mem_req),    32'd0);
        chk("flush_ready",   32'(bus.req_ready),  32'd1);
        chk("flush_no_wr",   32'(bus.cache_wr),   32'd0);
        chk("flush_no_done", 32'(bus.done_valid), 32'd0);
        tick(8);
        do_miss(32'h0000_2000, 32'h0040_006F, "after_flush");

        // Flush coincident with the WRITE cycle
        load_word(32'h0000_5000, 32'h1234_5678);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_5000;
        tick(1);
        bus.req_valid = 1'b0;
        tick(6);                                   // T+7 WRITE
        rob_clear_up = 1'b1;
        #1;
        chk("wflush_no_wr",   32'(bus.cache_wr),   32'd0);
        chk("wflush_no_done", 32'(bus.done_valid), 32'd0);
        tick(1);
        rob_clear_up = 1'b0;
        chk("wflush_ready", 32'(bus.req_ready), 32'd1);

        // Reset in the middle of READ
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1000;
        tick(1);
        bus.req_valid = 1'b0;
        tick(3);                                   // T+4 READ cnt 2
        rst_in = 1'b0;
        tick(1);
        chk("mrst_ready",      32'(bus.req_ready), 32'd1);
        chk("mrst_mem_req",    32'(bus.mem_req),   32'd0);
        chk("mrst_mem_a",      bus.mem_a,          32'd0);
        chk("mrst_cache_inst", bus.cache_inst,     32'd0);
        chk("mrst_cache_addr", bus.cache_addr,     32'd0);
`ifdef ICACHE_REFILL_STATS_EN
        chk("mrst_stat_miss",  stat_miss,  32'd0);
        chk("mrst_stat_abort", stat_abort, 32'd0);
`endif
        rst_in = 1'b1;
        tick(1);

        // Two completions and one abort (flush while waiting in ARB)
        do_miss(32'h0000_1000, 32'h0010_0513, "stat1");
        do_miss(32'h0000_2000, 32'h0040_006F, "stat2");
        bus.mem_gnt   = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_7000;
        tick(1);
        bus.req_valid = 1'b0;
        tick(1);
        rob_clear_up = 1'b1;
        tick(1);
        rob_clear_up = 1'b0;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
`ifdef ICACHE_REFILL_STATS_EN
        chk("stat_miss",  stat_miss,  32'd2);
        chk("stat_abort", stat_abort, 32'd1);
`endif
        tick(4);

        chk("sb_empty",     32'(sb.size()), 32'd0);
        chk("strobe_total", 32'(strobes),   32'(pushes));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
